// File: rtl/path_pkg.sv
// Shared constants and state encoding for the path sequencing stage.
package path_pkg;

   localparam int PATH_NODE_W = 5;
   localparam int PATH_DEPTH  = 16;
   localparam int PATH_PTR_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10
   } state_t;

   // Reserved marker for downstream stages; this stage never emits it.
   localparam logic [PATH_NODE_W-1:0] INVALID_NODE = '1;

endpackage

// File: rtl/path_buffer.sv
// Path node storage: synchronous write, two combinational read ports.
module path_buffer
   import path_pkg::*;
#(
   parameter int NODE_W = PATH_NODE_W,
   parameter int DEPTH  = PATH_DEPTH,
   parameter int PTR_W  = PATH_PTR_W
) (
   input  logic              clk_50M,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [NODE_W-1:0] wr_data,
   input  logic [PTR_W-1:0]  rd_addr_a,
   output logic [NODE_W-1:0] rd_data_a,
   input  logic [PTR_W-1:0]  rd_addr_b,
   output logic [NODE_W-1:0] rd_data_b
);

   logic [NODE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_50M) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/path_sequencer.sv
// Captures a planned node stream, then steps the navigator through it
// one node_reached handshake at a time.
module path_sequencer
   import path_pkg::*;
#(
   parameter int NODE_W = PATH_NODE_W,
   parameter int DEPTH  = PATH_DEPTH,
   parameter int PTR_W  = PATH_PTR_W
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic              node_valid,
   input  logic [NODE_W-1:0] node_in,
   input  logic              path_last,
   input  logic              node_reached,
   output logic [NODE_W-1:0] cur_node,
   output logic [NODE_W-1:0] target_node,
   output logic              target_valid,
   output logic [PTR_W:0]    path_len,
   output logic              path_done,
   output logic              overflow,
   output logic              busy
);

   localparam logic [PTR_W:0]   LEN_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

   state_t            state_reg, state_next;
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [PTR_W:0]    path_len_reg, path_len_next;
   logic [NODE_W-1:0] cur_node_reg, cur_node_next;
   logic [NODE_W-1:0] target_node_reg, target_node_next;
   logic              target_valid_reg, target_valid_next;
   logic              path_done_reg, path_done_next;
   logic              overflow_reg, overflow_next;
   logic              busy_reg, busy_next;
   logic              run_first_reg, run_first_next;

   logic              buf_we;
   logic [PTR_W-1:0]  buf_waddr;
   logic [PTR_W-1:0]  buf_raddr_b;
   logic [NODE_W-1:0] buf_rdata_a, buf_rdata_b;
   logic [PTR_W:0]    final_idx;

   path_buffer #(
      .NODE_W (NODE_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_buffer (
      .clk_50M   (clk_50M),
      .wr_en     (buf_we),
      .wr_addr   (buf_waddr),
      .wr_data   (node_in),
      .rd_addr_a ('0),
      .rd_data_a (buf_rdata_a),
      .rd_addr_b (buf_raddr_b),
      .rd_data_b (buf_rdata_b)
   );

   assign final_idx   = path_len_reg - (PTR_W+1)'(1);
   // Port B looks one node ahead of the current target.
   assign buf_raddr_b = run_first_reg ? PTR_W'(1) : rd_ptr_reg + PTR_W'(1);

   always_comb begin
      state_next        = state_reg;
      wr_ptr_next       = wr_ptr_reg;
      rd_ptr_next       = rd_ptr_reg;
      path_len_next     = path_len_reg;
      cur_node_next     = cur_node_reg;
      target_node_next  = target_node_reg;
      target_valid_next = target_valid_reg;
      path_done_next    = 1'b0;
      overflow_next     = overflow_reg;
      busy_next         = busy_reg;
      run_first_next    = 1'b0;
      buf_we            = 1'b0;
      buf_waddr         = wr_ptr_reg;

      case (state_reg)
         IDLE: begin
            if (node_valid) begin
               buf_we         = 1'b1;
               buf_waddr      = '0;
               wr_ptr_next    = PTR_W'(1);
               path_len_next  = (PTR_W+1)'(1);
               cur_node_next  = node_in;
               busy_next      = 1'b1;
               state_next     = path_last ? RUN : LOAD;
               run_first_next = path_last;
            end
         end
         LOAD: begin
            if (node_valid) begin
               if (path_len_reg == LEN_FULL) begin
                  overflow_next = 1'b1;
                  busy_next     = 1'b0;
                  state_next    = IDLE;
               end else begin
                  buf_we        = 1'b1;
                  // Saturate so the pointer cannot wrap onto buf[0].
                  wr_ptr_next   = (wr_ptr_reg == PTR_LAST) ? wr_ptr_reg
                                                           : wr_ptr_reg + PTR_W'(1);
                  path_len_next = path_len_reg + (PTR_W+1)'(1);
                  if (path_last) begin
                     state_next     = RUN;
                     run_first_next = 1'b1;
                  end
               end
            end
         end
         RUN: begin
            if (run_first_reg) begin
               rd_ptr_next   = PTR_W'(1);
               cur_node_next = buf_rdata_a;
               if (path_len_reg >= (PTR_W+1)'(2)) begin
                  target_node_next  = buf_rdata_b;
                  target_valid_next = 1'b1;
               end else begin
                  path_done_next = 1'b1;
                  busy_next      = 1'b0;
                  state_next     = IDLE;
               end
            end else if (node_reached) begin
               cur_node_next = target_node_reg;
               if ({1'b0, rd_ptr_reg} == final_idx) begin
                  target_valid_next = 1'b0;
                  path_done_next    = 1'b1;
                  busy_next         = 1'b0;
                  state_next        = IDLE;
               end else begin
                  rd_ptr_next      = rd_ptr_reg + PTR_W'(1);
                  target_node_next = buf_rdata_b;
               end
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         state_reg        <= IDLE;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         path_len_reg     <= '0;
         cur_node_reg     <= '0;
         target_node_reg  <= '0;
         target_valid_reg <= 1'b0;
         path_done_reg    <= 1'b0;
         overflow_reg     <= 1'b0;
         busy_reg         <= 1'b0;
         run_first_reg    <= 1'b0;
      end else begin
         state_reg        <= state_next;
         wr_ptr_reg       <= wr_ptr_next;
         rd_ptr_reg       <= rd_ptr_next;
         path_len_reg     <= path_len_next;
         cur_node_reg     <= cur_node_next;
         target_node_reg  <= target_node_next;
         target_valid_reg <= target_valid_next;
         path_done_reg    <= path_done_next;
         overflow_reg     <= overflow_next;
         busy_reg         <= busy_next;
         run_first_reg    <= run_first_next;
      end
   end

   assign cur_node     = cur_node_reg;
   assign target_node  = target_node_reg;
   assign target_valid = target_valid_reg;
   assign path_len     = path_len_reg;
   assign path_done    = path_done_reg;
   assign overflow     = overflow_reg;
   assign busy         = busy_reg;

endmodule

// File: tb/tb_path_sequencer.sv
// Scoreboard bench for path_sequencer: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_path_sequencer;

   localparam int NODE_W = 5;
   localparam int DEPTH  = 16;
   localparam int PTR_W  = 4;
   localparam int K_TGT  = 0;
   localparam int K_DONE = 1;
   localparam int K_OVF  = 2;

   typedef struct {
      int kind;
      int cyc;
      int cur;
      int tgt;
      int len;
   } ev_t;

   logic              clk_50M = 1'b0;
   logic              reset;
   logic              node_valid;
   logic [NODE_W-1:0] node_in;
   logic              path_last;
   logic              node_reached;
   logic [NODE_W-1:0] cur_node;
   logic [NODE_W-1:0] target_node;
   logic              target_valid;
   logic [PTR_W:0]    path_len;
   logic              path_done;
   logic              overflow;
   logic              busy;

   int  cyc    = 0;
   int  errors = 0;
   int  checks = 0;
   ev_t exp_q[$];
   int  path_q[$];
   bit  prev_tv  = 1'b0;
   bit  prev_ovf = 1'b0;
   int  prev_cur = 0;
   int  prev_tgt = 0;

   path_sequencer dut (
      .clk_50M      (clk_50M),
      .reset        (reset),
      .node_valid   (node_valid),
      .node_in      (node_in),
      .path_last    (path_last),
      .node_reached (node_reached),
      .cur_node     (cur_node),
      .target_node  (target_node),
      .target_valid (target_valid),
      .path_len     (path_len),
      .path_done    (path_done),
      .overflow     (overflow),
      .busy         (busy)
   );

   always #10 clk_50M = ~clk_50M;
   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   task automatic expect_ev(input int kind, input int c, input int cur, input int tgt, input int len);
      ev_t e;
      e.kind = kind; e.cyc = c; e.cur = cur; e.tgt = tgt; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic take_event(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_cycle", cyc, e.cyc);
         chk("ev_path_len", int'(path_len), e.len);
         if (e.cur >= 0) chk("ev_cur_node", int'(cur_node), e.cur);
         if (kind == K_TGT) begin
            chk("ev_target_node", int'(target_node), e.tgt);
         end else begin
            chk("ev_target_valid", int'(target_valid), 0);
            chk("ev_busy", int'(busy), 0);
         end
      end
   endtask

   always @(negedge clk_50M) begin
      if (path_done === 1'b1)
         take_event(K_DONE);
      else if (target_valid === 1'b1 &&
               (!prev_tv || int'(target_node) != prev_tgt || int'(cur_node) != prev_cur))
         take_event(K_TGT);
      if (overflow === 1'b1 && !prev_ovf)
         take_event(K_OVF);
      prev_tv  = (target_valid === 1'b1);
      prev_ovf = (overflow === 1'b1);
      prev_cur = int'(cur_node);
      prev_tgt = int'(target_node);
   end

   // Random path with no two adjacent nodes equal, so every step is visible.
   task automatic gen_path(input int n);
      int v;
      int prev;
      path_q.delete();
      prev = -1;
      for (int i = 0; i < n; i++) begin
         do v = $urandom_range(0, 31); while (v == prev);
         path_q.push_back(v);
         prev = v;
      end
   endtask

   task automatic load_path(input bit with_last, input bit noise);
      int n;
      int last_c;
      n = path_q.size();
      last_c = cyc;
      for (int i = 0; i < n; i++) begin
         node_valid   = 1'b1;
         node_in      = NODE_W'(path_q[i]);
         path_last    = with_last && (i == n - 1);
         node_reached = noise && ($urandom_range(0, 2) == 0);
         if (i == DEPTH) expect_ev(K_OVF, cyc + 1, -1, 0, DEPTH);
         last_c = cyc;
         tick();
      end
      node_valid   = 1'b0;
      path_last    = 1'b0;
      node_reached = noise && ($urandom_range(0, 1) == 0);
      if (with_last) begin
         if (n == 1) expect_ev(K_DONE, last_c + 2, path_q[0], 0, 1);
         else        expect_ev(K_TGT, last_c + 2, path_q[0], path_q[1], n);
      end
   endtask

   task automatic run_path(input int gap_min, input int gap_max, input bit poke30);
      int n;
      int rc;
      n = path_q.size();
      tick();
      node_reached = 1'b0;
      if (n > 1) begin
         for (int i = 1; i < n; i++) begin
            repeat ($urandom_range(gap_min, gap_max) - 1) tick();
            node_valid   = poke30 && ($urandom_range(0, 1) == 1);
            node_in      = NODE_W'(30);
            node_reached = 1'b1;
            rc = cyc;
            if (i == n - 1) expect_ev(K_DONE, rc + 1, path_q[n-1], 0, n);
            else            expect_ev(K_TGT, rc + 1, path_q[i], path_q[i+1], n);
            tick();
            node_reached = 1'b0;
            node_valid   = 1'b0;
         end
      end
      tick();
      chk("path_done_one_cycle", int'(path_done), 0);
      chk("idle_busy", int'(busy), 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cur_node"}, int'(cur_node), 0);
      chk({tag, "_target_node"}, int'(target_node), 0);
      chk({tag, "_target_valid"}, int'(target_valid), 0);
      chk({tag, "_path_len"}, int'(path_len), 0);
      chk({tag, "_path_done"}, int'(path_done), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int rc;
      reset = 1'b1; node_valid = 1'b0; node_in = '0; path_last = 1'b0; node_reached = 1'b0;
      repeat (3) tick();
      chk_reset_state("reset");
      reset = 1'b0;
      tick();

      path_q = '{3, 7, 12, 20, 25};
      load_path(1'b1, 1'b0);
      run_path(10, 10, 1'b0);
      chk("five_final_cur", int'(cur_node), 25);

      path_q = '{9};
      load_path(1'b1, 1'b1);
      run_path(1, 1, 1'b0);
      chk("single_cur", int'(cur_node), 9);
      node_reached = 1'b1;
      tick();
      node_reached = 1'b0;
      tick();
      chk("idle_reached_cur", int'(cur_node), 9);
      chk("idle_reached_tv", int'(target_valid), 0);

      path_q = '{2, 6};
      load_path(1'b1, 1'b1);
      run_path(1, 3, 1'b1);
      chk("b2b_cur_held", int'(cur_node), 6);
      chk("b2b_len_held", int'(path_len), 2);
      path_q = '{6, 11};
      load_path(1'b1, 1'b0);
      run_path(1, 3, 1'b1);

      for (int k = 0; k < 25; k++) begin
         gen_path($urandom_range(1, DEPTH));
         load_path(1'b1, 1'($urandom_range(0, 1)));
         run_path(1, 4, 1'b1);
         repeat ($urandom_range(0, 3)) begin
            node_reached = 1'($urandom_range(0, 1));
            tick();
         end
         node_reached = 1'b0;
         chk("idle_cur_hold", int'(cur_node), path_q[path_q.size()-1]);
      end
      chk("no_overflow_yet", int'(overflow), 0);

      path_q.delete();
      for (int i = 0; i <= DEPTH; i++) path_q.push_back(i);
      load_path(1'b0, 1'b0);
      node_reached = 1'b0;
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_busy", int'(busy), 0);
      chk("ovf_path_len", int'(path_len), DEPTH);
      tick();
      path_q = '{5, 6, 7};
      load_path(1'b1, 1'b0);
      run_path(1, 2, 1'b0);
      chk("ovf_sticky", int'(overflow), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("ovf_cleared", int'(overflow), 0);

      path_q = '{1, 2, 3};
      load_path(1'b1, 1'b0);
      tick();
      node_reached = 1'b1;
      rc = cyc;
      expect_ev(K_TGT, rc + 1, 2, 3, 3);
      tick();
      node_reached = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_state("midrun");
      repeat (5) tick();
      path_q = '{4, 5};
      load_path(1'b1, 1'b0);
      run_path(2, 5, 1'b0);
      chk("last_cur", int'(cur_node), 5);

      repeat (4) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
- Downstream of the CPU path-planner driver. Captures the serial stream of planned node IDs that the driver emits after the CPU finishes.
- Buffers up to DEPTH nodes and then releases them one at a time to the bot's line-follower/navigation logic. Each release is gated by a node-reached handshake.
- Reports the current node, the next target, path completion and overflow.

Parameters:
- NODE_W, 5: width of a node ID.
- DEPTH, 16: maximum path length in nodes.
- PTR_W, 4: index width; must satisfy 2**PTR_W == DEPTH.

Ports:
- clk_50M  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- node_valid  in  1  one-cycle strobe; node_in is a path node this cycle.
- node_in  in  NODE_W  planned node ID.
- path_last  in  1  qualifies node_valid; the node is the final (end-point) node.
- node_reached  in  1  one-cycle pulse from the navigator: target node reached.
- cur_node  out  NODE_W  node the bot is at; reset 0.
- target_node  out  NODE_W  node the bot must drive to; reset 0.
- target_valid  out  1  target_node is meaningful; reset 0.
- path_len  out  PTR_W+1  number of nodes captured; reset 0.
- path_done  out  1  one-cycle pulse when the final node is reached; reset 0.
- overflow  out  1  sticky error flag; reset 0.
- busy  out  1  high in LOAD or RUN; reset 0.

Behaviour:
- All registers update on the rising edge of clk_50M. When reset=1, every output goes to its reset value, state goes to IDLE, and all pointers clear. Buffer contents need not be cleared.
- IDLE:
  - node_valid=1 writes node_in to buf[0], sets wr_ptr=1, path_len=1 and busy=1. Next state is LOAD.
  - If path_last is also 1, next state is RUN instead (single-node path).
- LOAD:
  - Each node_valid writes buf[wr_ptr], then increments wr_ptr and path_len.
  - path_last=1 with node_valid: the write completes and the next state is RUN.
  - node_valid when path_len==DEPTH: the node is dropped, overflow is set (sticky until reset), and the next state is IDLE with busy=0.
  - node_reached is ignored in LOAD and IDLE.
- RUN entry (first cycle in RUN): rd_ptr=1 and cur_node=buf[0].
  - If path_len>=2: target_node=buf[1] and target_valid=1.
  - If path_len==1: path_done pulses the next cycle, target_valid stays 0, and the next state is IDLE.
- RUN, on a node_reached pulse:
  - cur_node <= target_node.
  - If rd_ptr==path_len-1 (final node): target_valid <= 0, path_done pulses for exactly one cycle in the same cycle, busy <= 0, next state is IDLE.
  - Otherwise: rd_ptr increments and target_node <= buf[rd_ptr+1] in the same cycle. target_valid stays 1 with no bubble.
- Latency:
  - A node_valid with path_last=1 produces target_valid=1 two cycles later.
  - node_reached updates target_node on the next edge, with 1-cycle latency.
- node_valid while in RUN is dropped and does not set overflow. A new path is accepted only from IDLE.
- cur_node and path_len hold their values in IDLE after completion, so the navigator can still read them. They are overwritten when the next path's first node arrives.
- A node_reached that coincides with the RUN-entry cycle is ignored.
- A reset asserted mid-LOAD or mid-RUN aborts immediately; path_done does not pulse.
- Width rules:
  - path_len is PTR_W+1 bits wide so it can hold DEPTH.
  - rd_ptr and wr_ptr are PTR_W bits and never wrap: the overflow check blocks writes before wrap.

Decomposition:
- Shared package, path_pkg:
  - NODE_W and DEPTH constants.
  - State encoding IDLE=2'b00, LOAD=2'b01, RUN=2'b10.
  - INVALID_NODE constant (all ones), reserved for other stages.
- One natural sub-module: path_buffer, a DEPTH x NODE_W register file with a synchronous write port and a combinational read port. The sequencer FSM and pointers stay in path_sequencer.

Test Plan:
- Five-node path: reset, then stream 3,7,12,20,25 on consecutive cycles with path_last on 25.
  - Expect path_len=5, cur_node=3, target_node=7, target_valid=1 two cycles after the last node.
  - Four node_reached pulses spaced 10 cycles apart: target_node steps 12,20,25. After the 4th pulse, cur_node=25, target_valid=0, path_done high exactly one cycle, busy=0.
- Single-node path: node_valid with node_in=9 and path_last=1 in IDLE.
  - Expect cur_node=9, target_valid never 1, path_done pulses once, return to IDLE.
- Overflow: stream 17 nodes (0..16) with no path_last.
  - Expect overflow=1 on the 17th node, busy=0, state IDLE, path_len=16.
  - overflow stays 1 after a following valid path and clears only on reset.
- Mid-run reset: during RUN of path 1,2,3, assert reset for 1 cycle after the first node_reached.
  - Expect all outputs at reset values next cycle and no path_done pulse.
  - A new path 4,5 then runs normally.
- Ignored inputs:
  - node_reached pulses in IDLE and LOAD: no change to cur_node or target_node.
  - node_valid with value 30 in RUN: no change to buffer or path_len, overflow stays 0.
- Back-to-back paths: after path_done for path 2,6 (cur_node=6 held), send path 6,11.
  - Expect cur_node=6 and target_node=11 with path_len=2.
